// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered, start/data(LSB first)/stop frames at CLK = OVERSAMPLE x baud; TX falls one cycle after the first push.
// TX_READY drops while the FIFO is full; optional even parity bit via macro UART_TX_PARITY_EN.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     push_vld,
  output logic                     push_rdy,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic                     pop_vld,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign push_rdy = (count < FULL);
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign push     = push_vld && push_rdy;
  assign pop      = pop_rdy && pop_vld;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap modulo DEPTH; count alone tells full from empty.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          arst_i,
  input  logic [DATA_BITS-1:0]          TX_DATA,
  input  logic                          TX_VALID,
  output logic                          TX_READY,
  output logic                          TX,
  output logic                          TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tick, tick_nxt;
  logic [IW-1:0]        bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shifter, shift_nxt;
  logic                 tx_nxt;
  logic                 bit_end;
  logic                 pop;
  logic                 fifo_vld;
  logic [DATA_BITS-1:0] fifo_dat;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_nxt;
`endif

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (CLK),
    .arst     (arst_i),
    .push_vld (TX_VALID),
    .push_rdy (TX_READY),
    .push_dat (TX_DATA),
    .pop_rdy  (pop),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_dat),
    .count    (FIFO_COUNT)
  );

  assign bit_end = (tick == TICK_LAST);
  assign TX_BUSY = (state != IDLE);

  always_comb begin
    state_nxt = state;
    tick_nxt  = '0;
    bit_nxt   = bit_idx;
    shift_nxt = shifter;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    if (state != IDLE) tick_nxt = bit_end ? '0 : tick + 1'b1;

    case (state)
      IDLE: begin
        if (fifo_vld) begin
          pop       = 1'b1;
          shift_nxt = fifo_dat;
          state_nxt = START;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^fifo_dat;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shifter >> 1;
          bit_nxt   = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        // Back-to-back frames: a queued byte goes straight into a new start bit.
        if (bit_end) begin
          if (fifo_vld) begin
            pop       = 1'b1;
            shift_nxt = fifo_dat;
            state_nxt = START;
`ifdef UART_TX_PARITY_EN
            par_nxt   = ^fifo_dat;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // TX is registered from the next state so the line moves on the same edge as the FSM.
    tx_nxt = 1'b1;
    case (state_nxt)
      IDLE:    tx_nxt = 1'b1;
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = par_nxt;
`endif
      STOP:    tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge arst_i) begin
    if (arst_i) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shifter <= '0;
      TX      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      tick    <= tick_nxt;
      bit_idx <= bit_nxt;
      shifter <= shift_nxt;
      TX      <= tx_nxt;
`ifdef UART_TX_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart of the team's 16x-oversampled UART receiver.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1); idle line high.
- CLK runs at OVERSAMPLE x baud; no internal baud divider.
- A small FIFO decouples the byte producer (LED/IoT control logic) from the serial line so bytes can be queued while a frame is in flight.

Parameters:
- OVERSAMPLE, 16, CLK cycles per serial bit; legal range 4..16.
- DATA_BITS, 8, data bits per frame.
- FIFO_DEPTH, 4, holding FIFO entries; power of two, 2..16.

Ports:
- CLK  input  1  oversample clock (16x baud).
- arst_i  input  1  reset arst_i, asynchronous, active-high; clock CLK.
- TX_DATA  input  DATA_BITS  byte to send.
- TX_VALID  input  1  producer has a byte on TX_DATA.
- TX_READY  output  1  FIFO can accept; high when count < FIFO_DEPTH.
- TX  output  1  serial line, registered.
- TX_BUSY  output  1  high while any frame bit (start..stop) is being driven.
- FIFO_COUNT  output  clog2(FIFO_DEPTH)+1  bytes queued, excluding the one in the shifter.

Behaviour:
- Reset (async, arst_i=1):
  - TX=1, TX_BUSY=0, FIFO_COUNT=0, TX_READY=1 immediately.
  - FIFO pointers, shifter, bit counter and tick counter cleared; state IDLE.
  - Reset mid-frame aborts the frame; line returns high at once; queued bytes are lost.
- Push: on a CLK edge with TX_VALID && TX_READY, TX_DATA is written and the count increments. TX_VALID while full is ignored (no write, no overflow).
- Pop: the FSM takes the FIFO head when leaving IDLE or finishing STOP.
  - Push and pop on the same edge leave the count unchanged; both take effect.
  - A push into an empty FIFO plus a pop on the same edge is not possible, because pop needs count>0 before the edge.
- Tick counter: counts 0..OVERSAMPLE-1 in every non-IDLE state; a bit ends when the counter reaches OVERSAMPLE-1; held at 0 in IDLE.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: TX=1. If count>0: pop into the shifter, go to START. TX=0 from that same edge.
  - START: TX=0 for OVERSAMPLE cycles, then DATA with bit index 0.
  - DATA: TX=shifter[0]; at each bit end, shift right and increment the index. After DATA_BITS bits, go to PARITY (if enabled) or STOP.
  - STOP: TX=1 for OVERSAMPLE cycles. At the end, if count>0, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Latency:
  - First push into an idle, empty block at edge k → count=1 after k.
  - TX falls at edge k+1.
  - Frame length is exactly (DATA_BITS+2)*OVERSAMPLE cycles; 160 at defaults, 176 with parity.
- TX_BUSY=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Wrap-around: FIFO pointers are modulo FIFO_DEPTH; the count distinguishes full from empty.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - TX = even parity (XOR of all data bits) for OVERSAMPLE cycles.
  - Frame = DATA_BITS+3 bits.
- Undefined: no PARITY state or parity logic; frame = DATA_BITS+2 bits.

Test Plan:
- Single byte: reset, push 0xA5 once.
  - TX goes 0 one cycle after the push.
  - Then bits 1,0,1,0,0,1,0,1 (LSB first), then 1; each held 16 cycles.
  - TX_BUSY high for 160 cycles, then IDLE.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles.
  - Second start bit begins exactly 160 cycles after the first.
  - TX stays high for only the 16-cycle stop bit between frames.
- Full/backpressure: push 6 bytes on consecutive cycles at defaults.
  - 1st moves to the shifter; the next 4 fill the FIFO; TX_READY drops after the 5th push (FIFO_COUNT=4).
  - 6th byte is not accepted.
  - TX_READY reasserts one cycle after the first frame's stop bit ends (pop).
- Reset mid-frame: assert arst_i at cycle 70 of a 0x3C frame.
  - TX=1 and FIFO_COUNT=0 immediately.
  - No further frames after release until a new push.
- Loopback: wire TX to the team's receiver (same CLK) and send 0x55, 0x81, 0xFE. Receiver DATAREC shows each byte after its frame.
- With UART_TX_PARITY_EN: push 0x07.
  - Parity bit = 1 after data bit 7.
  - Frame = 176 cycles.
  - 0x03 gives parity bit 0.
